// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite transfer types, size codes and alignment helper
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BUSY = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR  = 3'd3,
    ST_ERR1 = 3'd4,
    ST_ERR2 = 3'd5
  } ctrl_state_t;

  // Legal size (byte/half/word) whose address is naturally aligned.
  function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: xfer_legal = 1'b1;
      HSIZE_HALF: xfer_legal = ~addr_lo[0];
      HSIZE_WORD: xfer_legal = (addr_lo == 2'b00);
      default:    xfer_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - clearable up-counter with programmable rollover value and flag
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) count_out <= NUM_CNT_BITS'(1);
      else                           count_out <= count_out + 1'b1;
    end
  end

  assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/ahb_transfer_controller.sv
// rtl/ahb_transfer_controller.sv - AHB-Lite slave transfer sequencer; BUS_TIMEOUT_EN enables BUSY timeout abort
module ahb_transfer_controller
  import ahb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              be_req,
  output logic              be_write,
  output logic [ADDR_W-1:0] be_addr,
  output logic [2:0]        be_size,
  output logic [DATA_W-1:0] be_wdata,
  input  logic              be_ack,
  input  logic              be_err,
  input  logic [DATA_W-1:0] be_rdata,
  output logic              resp_enable,
  output logic              resp_ready,
  output logic              resp_error
);

  ctrl_state_t state, state_nxt;
  htrans_t     htrans;
  logic        addr_phase;
  logic        xfer_active;
  logic        xfer_ok;
  logic        timeout_hit;

  assign htrans      = htrans_t'(HTRANS);
  assign xfer_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  assign addr_phase  = (state == ST_IDLE) && HSEL && HREADY;
  assign xfer_ok     = xfer_legal(HSIZE, HADDR[1:0]);
  assign be_wdata    = HWDATA;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] busy_count_unused;

  flex_counter #(
    .NUM_CNT_BITS(CNT_W)
  ) u_timeout_cnt (
    .clk          (HCLK),
    .n_rst        (HRESETn),
    .clear        (addr_phase && xfer_active && xfer_ok),
    .count_enable (state == ST_BUSY),
    .rollover_val (CNT_W'(TIMEOUT - 1)),
    .count_out    (busy_count_unused),
    .rollover_flag(timeout_hit)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT < 2);
  assign timeout_hit    = 1'b0;
`endif

  // be_err outranks be_ack, and be_ack outranks the timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (addr_phase && xfer_active) state_nxt = xfer_ok ? ST_BUSY : ST_ERR;
      ST_BUSY: begin
        if (be_err)           state_nxt = ST_ERR;
        else if (be_ack)      state_nxt = ST_DONE;
        else if (timeout_hit) state_nxt = ST_ERR;
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_ERR1;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      HRDATA      <= '0;
      be_req      <= 1'b0;
      be_write    <= 1'b0;
      be_addr     <= '0;
      be_size     <= '0;
      resp_enable <= 1'b0;
      resp_ready  <= 1'b0;
      resp_error  <= 1'b0;
    end else begin
      state       <= state_nxt;
      be_req      <= (state_nxt == ST_BUSY);
      resp_enable <= 1'b1;
      resp_ready  <= (state_nxt == ST_DONE) || (addr_phase && !xfer_active);
      resp_error  <= (state_nxt == ST_ERR);
      if (addr_phase && xfer_active) begin
        be_write <= HWRITE;
        be_addr  <= HADDR;
        be_size  <= HSIZE;
      end
      if ((state == ST_BUSY) && !be_err && be_ack && !be_write) HRDATA <= be_rdata;
    end
  end

endmodule

// File: tb/tb_ahb_transfer_controller.sv
// tb/tb_ahb_transfer_controller.sv - directed self-checking bench for ahb_transfer_controller
module tb_ahb_transfer_controller;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [7:0]  HADDR;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        be_req;
  logic        be_write;
  logic [7:0]  be_addr;
  logic [2:0]  be_size;
  logic [31:0] be_wdata;
  logic        be_ack;
  logic        be_err;
  logic [31:0] be_rdata;
  logic        resp_enable;
  logic        resp_ready;
  logic        resp_error;

  int vec_cnt = 0;
  int err_cnt = 0;

  ahb_transfer_controller #(
    .ADDR_W(8), .DATA_W(32), .TIMEOUT(16)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .be_req(be_req), .be_write(be_write), .be_addr(be_addr), .be_size(be_size),
    .be_wdata(be_wdata), .be_ack(be_ack), .be_err(be_err), .be_rdata(be_rdata),
    .resp_enable(resp_enable), .resp_ready(resp_ready), .resp_error(resp_error)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic wr, input logic [7:0] addr, input logic [2:0] size,
                            input logic [1:0] trans);
    HSEL   = 1'b1;
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = addr;
    HSIZE  = size;
    tick();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
    HADDR = 8'h00; HWDATA = 32'h0; HREADY = 1'b1;
    be_ack = 1'b0; be_err = 1'b0; be_rdata = 32'h0;

    #3;
    check_vec("rst_be_req", be_req, 0);
    check_vec("rst_resp_enable", resp_enable, 0);
    check_vec("rst_hrdata", HRDATA, 0);
    check_vec("rst_resp_ready", resp_ready, 0);
    check_vec("rst_resp_error", resp_error, 0);
    tick();
    HRESETn = 1'b1;
    check_vec("rel_resp_enable_low", resp_enable, 0);
    tick();
    check_vec("rel_resp_enable_high", resp_enable, 1);

    // NONSEQ word read, ack in the third BUSY cycle
    addr_phase(1'b0, 8'h04, 3'd2, 2'b10);
    check_vec("rd_be_req", be_req, 1);
    check_vec("rd_be_addr", be_addr, 32'h04);
    check_vec("rd_be_write", be_write, 0);
    check_vec("rd_be_size", be_size, 2);
    tick();
    check_vec("rd_busy2_ready", resp_ready, 0);
    tick();
    be_ack = 1'b1; be_rdata = 32'hDEADBEEF;
    tick();
    be_ack = 1'b0;
    check_vec("rd_resp_ready", resp_ready, 1);
    check_vec("rd_hrdata", HRDATA, 32'hDEADBEEF);
    check_vec("rd_be_req_fall", be_req, 0);
    tick();
    check_vec("rd_ready_once", resp_ready, 0);

    // zero-wait read: resp_ready two cycles after the address phase
    addr_phase(1'b0, 8'h08, 3'd2, 2'b11);
    be_ack = 1'b1; be_rdata = 32'h12345678;
    check_vec("zw_ready_early", resp_ready, 0);
    tick();
    be_ack = 1'b0;
    check_vec("zw_ready", resp_ready, 1);
    check_vec("zw_hrdata", HRDATA, 32'h12345678);
    tick();

    // misaligned halfword write: ERR for three cycles, bus ignored meanwhile
    addr_phase(1'b1, 8'h03, 3'd1, 2'b10);
    check_vec("mis_be_req", be_req, 0);
    check_vec("mis_resp_error", resp_error, 1);
    check_vec("mis_be_addr", be_addr, 32'h03);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 8'h00; HSIZE = 3'd2;
    tick();
    check_vec("mis_error_once", resp_error, 0);
    tick();
    check_vec("mis_err2_be_req", be_req, 0);
    tick();
    check_vec("mis_ignored_be_req", be_req, 0);
    check_vec("mis_ignored_addr", be_addr, 32'h03);
    // IDLE transfer proves the FSM is back in IDLE
    HTRANS = 2'b00;
    tick();
    HSEL = 1'b0;
    check_vec("idle_resp_ready", resp_ready, 1);
    check_vec("idle_be_req", be_req, 0);
    tick();
    check_vec("idle_ready_once", resp_ready, 0);

    // illegal HSIZE
    addr_phase(1'b0, 8'h00, 3'd3, 2'b10);
    check_vec("sz3_resp_error", resp_error, 1);
    check_vec("sz3_be_req", be_req, 0);
    repeat (3) tick();

    // ack and err together: error wins, HRDATA untouched
    addr_phase(1'b0, 8'h10, 3'd0, 2'b10);
    be_ack = 1'b1; be_err = 1'b1; be_rdata = 32'hCAFEF00D;
    tick();
    be_ack = 1'b0; be_err = 1'b0;
    check_vec("both_resp_error", resp_error, 1);
    check_vec("both_resp_ready", resp_ready, 0);
    check_vec("both_hrdata", HRDATA, 32'h12345678);
    repeat (3) tick();

    // write: data passes through, HRDATA unchanged
    HWDATA = 32'hA5A55A5A;
    addr_phase(1'b1, 8'h20, 3'd2, 2'b10);
    check_vec("wr_be_wdata", be_wdata, 32'hA5A55A5A);
    check_vec("wr_be_write", be_write, 1);
    be_ack = 1'b1; be_rdata = 32'h11111111;
    tick();
    be_ack = 1'b0;
    check_vec("wr_resp_ready", resp_ready, 1);
    check_vec("wr_hrdata", HRDATA, 32'h12345678);
    tick();

    // unacknowledged access
    addr_phase(1'b0, 8'h40, 3'd2, 2'b10);
`ifdef BUS_TIMEOUT_EN
    n = 0;
    while (be_req && n < 40) begin
      n++;
      tick();
    end
    check_vec("to_req_cycles", n, 16);
    check_vec("to_resp_error", resp_error, 1);
    repeat (3) tick();
`else
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (be_req) n++;
      tick();
    end
    check_vec("nto_req_cycles", n, 100);
    check_vec("nto_still_req", be_req, 1);
    be_ack = 1'b1; be_rdata = 32'h0BADF00D;
    tick();
    be_ack = 1'b0;
    check_vec("nto_resp_ready", resp_ready, 1);
    check_vec("nto_hrdata", HRDATA, 32'h0BADF00D);
    tick();
`endif

    // asynchronous reset mid-BUSY
    addr_phase(1'b0, 8'h0C, 3'd2, 2'b10);
    check_vec("mr_be_req_before", be_req, 1);
    #2 HRESETn = 1'b0;
    #1;
    check_vec("mr_be_req_async", be_req, 0);
    check_vec("mr_resp_enable", resp_enable, 0);
    check_vec("mr_hrdata", HRDATA, 0);
    tick();
    HRESETn = 1'b1;
    check_vec("mr_rel_enable_low", resp_enable, 0);
    tick();
    check_vec("mr_rel_enable_high", resp_enable, 1);
    check_vec("mr_rel_be_req", be_req, 0);
    HSEL = 1'b1; HTRANS = 2'b00;
    tick();
    HSEL = 1'b0;
    check_vec("mr_idle_ready", resp_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
